// File: rtl/cond_logic_pkg.sv
// rtl/cond_logic_pkg.sv - shared condition-code and flag-index definitions for cond_logic
package cond_logic_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_logic_if.sv
// rtl/cond_logic_if.sv - decoder/ALU-facing signal bundle of the conditional-execution stage
interface cond_logic_if #(parameter int CNT_W = 16);

   logic             InstrValid;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS;
   logic             RegW;
   logic             MemW;
   logic             NoWrite;
   logic             FlagSave;
   logic             FlagRestore;
   logic             CntClr;
   logic             PCSrc;
   logic             RegWrite;
   logic             MemWrite;
   logic             CondEx;
   logic [3:0]       Flags;
   logic [3:0]       SavedFlags;
   logic [CNT_W-1:0] ExecCount;
   logic [CNT_W-1:0] SquashCount;

   modport master (
      output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
             FlagSave, FlagRestore, CntClr,
      input  PCSrc, RegWrite, MemWrite, CondEx, Flags, SavedFlags,
             ExecCount, SquashCount
   );

   modport slave (
      input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
             FlagSave, FlagRestore, CntClr,
      output PCSrc, RegWrite, MemWrite, CondEx, Flags, SavedFlags,
             ExecCount, SquashCount
   );

endinterface

// File: rtl/cond_logic_cond_check.sv
// rtl/cond_logic_cond_check.sv - combinational evaluation of an ARM condition field against NZCV
module cond_check
   import cond_logic_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - conditional-execution stage: NZCV flags, shadow flags, write gating, debug counters
module cond_logic
   import cond_logic_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   cond_logic_if.slave     bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0]       flags_q;
   logic [3:0]       saved_q;
   logic [3:0]       flags_d;
   logic [CNT_W-1:0] exec_q;
   logic [CNT_W-1:0] squash_q;
   logic             cond_ex;
   logic             active;
   logic [1:0]       flag_write;

   // Evaluated on the registered flags, so a flag-setting instruction sees the old NZCV.
   cond_check u_cond_check (
      .cond    (bus.Cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   assign active     = cond_ex & bus.InstrValid;
   assign flag_write = bus.FlagW & {2{active}};

   assign bus.CondEx      = cond_ex;
   assign bus.PCSrc       = bus.PCS & active;
   assign bus.RegWrite    = bus.RegW & ~bus.NoWrite & active;
   assign bus.MemWrite    = bus.MemW & active;
   assign bus.Flags       = flags_q;
   assign bus.SavedFlags  = saved_q;
   assign bus.ExecCount   = exec_q;
   assign bus.SquashCount = squash_q;

   always_comb begin
      flags_d = flags_q;
      if (flag_write[1]) begin
         flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
         flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
      end
      if (flag_write[0]) begin
         flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
         flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
      end
      // Restore wins over the ALU; with a concurrent save this becomes a swap.
      if (bus.FlagRestore) begin
         flags_d = saved_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q <= 4'b0000;
         saved_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
         if (bus.FlagSave) begin
            saved_q <= flags_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exec_q   <= '0;
         squash_q <= '0;
      end else if (bus.CntClr) begin
         exec_q   <= '0;
         squash_q <= '0;
      end else if (bus.InstrValid) begin
         if (cond_ex && exec_q != CNT_MAX) begin
            exec_q <= exec_q + 1'b1;
         end
         if (!cond_ex && squash_q != CNT_MAX) begin
            squash_q <= squash_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - randomized and directed self-checking bench for cond_logic
module tb_cond_logic;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   logic [3:0] m_flags;
   logic [3:0] m_saved;
   int         m_exec;
   int         m_squash;

   cond_logic_if #(.CNT_W(CW)) bus ();

   cond_logic #(.CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_inputs(input bit valid, input logic [3:0] cond, input logic [3:0] alu,
                             input logic [1:0] fw, input bit save, input bit restore, input bit clr);
      bus.InstrValid  = valid;
      bus.Cond        = cond;
      bus.ALUFlags    = alu;
      bus.FlagW       = fw;
      bus.FlagSave    = save;
      bus.FlagRestore = restore;
      bus.CntClr      = clr;
   endtask

   task automatic check_state(input string tag);
      check({tag, ":flags"},  32'(bus.Flags),       32'(m_flags));
      check({tag, ":saved"},  32'(bus.SavedFlags),  32'(m_saved));
      check({tag, ":exec"},   32'(bus.ExecCount),   32'(m_exec));
      check({tag, ":squash"}, 32'(bus.SquashCount), 32'(m_squash));
   endtask

   // Checks combinational outputs, clocks once, advances the model, checks registered state.
   task automatic do_cycle(input string tag);
      bit         p;
      logic [3:0] nf;
      #1;
      p = ref_pass(bus.Cond, m_flags);
      check({tag, ":condex"}, 32'(bus.CondEx),   32'(p));
      check({tag, ":pcsrc"},  32'(bus.PCSrc),    32'(bus.PCS && p && bus.InstrValid));
      check({tag, ":regw"},   32'(bus.RegWrite), 32'(bus.RegW && !bus.NoWrite && p && bus.InstrValid));
      check({tag, ":memw"},   32'(bus.MemWrite), 32'(bus.MemW && p && bus.InstrValid));
      @(posedge clk);
      nf = m_flags;
      if (p && bus.InstrValid && bus.FlagW[1]) nf[3:2] = bus.ALUFlags[3:2];
      if (p && bus.InstrValid && bus.FlagW[0]) nf[1:0] = bus.ALUFlags[1:0];
      if (bus.FlagRestore) nf = m_saved;
      if (bus.FlagSave) m_saved = m_flags;
      m_flags = nf;
      if (bus.CntClr) begin
         m_exec = 0;
         m_squash = 0;
      end else if (bus.InstrValid) begin
         if (p) m_exec = (m_exec < CMAX) ? m_exec + 1 : CMAX;
         else   m_squash = (m_squash < CMAX) ? m_squash + 1 : CMAX;
      end
      #1;
      check_state(tag);
   endtask

   task automatic load_flags(input logic [3:0] f);
      set_inputs(1'b1, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0);
      do_cycle("load");
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_flags  = 4'b0; m_saved = 4'b0; m_exec = 0; m_squash = 0;
      bus.PCS = 1'b0; bus.RegW = 1'b1; bus.MemW = 1'b0; bus.NoWrite = 1'b0;

      // Reset state with an AL instruction presented
      reset = 1'b0;
      set_inputs(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      #1;
      check_state("rst");
      check("rst:condex", 32'(bus.CondEx), 32'd1);
      check("rst:regw",   32'(bus.RegWrite), 32'd1);
      #1;
      reset = 1'b1;
      bus.Cond = 4'b0000;
      #1;
      check("eq0:condex", 32'(bus.CondEx), 32'd0);
      check("eq0:regw",   32'(bus.RegWrite), 32'd0);

      // Flag write latency and evaluation on old flags
      load_flags(4'b0100);
      check("t2:flags", 32'(bus.Flags), 32'h4);
      bus.Cond = 4'b0000; #1;
      check("t2:eq", 32'(bus.CondEx), 32'd1);
      bus.Cond = 4'b1000; #1;
      check("t2:hi", 32'(bus.CondEx), 32'd0);
      set_inputs(1'b1, 4'b0001, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0);
      do_cycle("t3");
      check("t3:flags", 32'(bus.Flags), 32'h4);
      check("t3:squash", 32'(bus.SquashCount), 32'd1);

      // Partial flag write
      set_inputs(1'b1, 4'b1110, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0);
      do_cycle("t4");
      check("t4:flags", 32'(bus.Flags), 32'h8);

      // Full condition table sweep, bubbles so no side effects
      for (int f = 0; f < 16; f++) begin
         load_flags(4'(f));
         bus.InstrValid = 1'b0;
         for (int c = 0; c < 16; c++) begin
            bus.Cond = 4'(c);
            #1;
            check($sformatf("sweep f%0h c%0h", f, c), 32'(bus.CondEx), 32'(ref_pass(4'(c), 4'(f))));
            check($sformatf("sweep bubble regw f%0h c%0h", f, c), 32'(bus.RegWrite), 32'd0);
         end
      end

      // Shadow register save / write / restore-priority / swap
      load_flags(4'b0110);
      set_inputs(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
      do_cycle("t5save");
      check("t5:saved", 32'(bus.SavedFlags), 32'h6);
      load_flags(4'b1001);
      check("t5:wr", 32'(bus.Flags), 32'h9);
      set_inputs(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0);
      do_cycle("t5rest");
      check("t5:rest", 32'(bus.Flags), 32'h6);
      load_flags(4'b1010);
      set_inputs(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0);
      do_cycle("t5swap");
      check("t5:swapf", 32'(bus.Flags), 32'h6);
      check("t5:swaps", 32'(bus.SavedFlags), 32'hA);

      // Counter saturation and clear priority
      for (int i = 0; i < 20; i++) begin
         set_inputs(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
         do_cycle("t6inc");
      end
      check("t6:sat", 32'(bus.ExecCount), 32'(CMAX));
      set_inputs(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1);
      do_cycle("t6clr");
      check("t6:clr", 32'(bus.ExecCount), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         set_inputs($urandom_range(3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
                    $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(29) == 0);
         bus.PCS     = 1'($urandom);
         bus.RegW    = 1'($urandom);
         bus.MemW    = 1'($urandom);
         bus.NoWrite = 1'($urandom);
         do_cycle("rand");
      end

      // Asynchronous reset mid-cycle
      set_inputs(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0);
      do_cycle("prerst");
      reset = 1'b0;
      #1;
      m_flags = 4'b0; m_saved = 4'b0; m_exec = 0; m_squash = 0;
      check_state("arst");
      #2;
      reset = 1'b1;
      set_inputs(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
      do_cycle("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the ALU in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register, which is loaded from the ALU's 4-bit flag output {N,Z,C,V}.
- Evaluates the instruction's 4-bit condition field against the stored flags and squashes PC, register and memory writes when the condition fails.
- Also provides a shadow flag register for exception entry/return, plus saturating executed/squashed instruction counters for debug.

Parameters:
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
InstrValid  in  1  current instruction is real; 0 = bubble, no side effects
Cond  in  4  instruction condition field Instr[31:28]
ALUFlags  in  4  {N,Z,C,V} from ALU for the current instruction
FlagW  in  2  [1]: update N,Z; [0]: update C,V (decoder, S-bit gated)
PCS  in  1  decoder: instruction writes PC
RegW  in  1  decoder: instruction writes register file
MemW  in  1  decoder: instruction writes memory
NoWrite  in  1  decoder: compare-type op, suppress RegWrite
FlagSave  in  1  copy Flags into shadow register
FlagRestore  in  1  load Flags from shadow register
CntClr  in  1  synchronous clear of both counters
PCSrc  out  1  gated PCS
RegWrite  out  1  gated RegW
MemWrite  out  1  gated MemW
CondEx  out  1  condition passed for current instruction
Flags  out  4  registered {N,Z,C,V}
SavedFlags  out  4  registered shadow flags
ExecCount  out  CNT_W  valid instructions with CondEx=1
SquashCount  out  CNT_W  valid instructions with CondEx=0

Behaviour:
- Reset (reset=0, asynchronous): Flags=0, SavedFlags=0, ExecCount=0, SquashCount=0. Combinational outputs follow these values.
- CondEx is combinational from the registered Flags (never ALUFlags) and Cond:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 is reserved and treated as never (0).
- Gating (combinational, zero latency):
  - PCSrc = PCS&CondEx&InstrValid
  - RegWrite = RegW&~NoWrite&CondEx&InstrValid
  - MemWrite = MemW&CondEx&InstrValid
- Flag update on the rising clock edge, where FlagWrite = FlagW & {2{CondEx&InstrValid}}:
  - FlagWrite[1] loads Flags[3:2] from ALUFlags[3:2].
  - FlagWrite[0] loads Flags[1:0] from ALUFlags[1:0].
  - The new flags are visible to the next instruction's CondEx (one-cycle latency). The instruction that writes the flags is evaluated on the old flags.
- Shadow register:
  - FlagSave=1: SavedFlags <= current registered Flags, i.e. the pre-update value, even if a flag write occurs the same cycle.
  - FlagRestore=1: Flags <= SavedFlags. This has priority over any ALU flag write in that cycle.
  - Save and restore in the same cycle swap the two registers.
  - Save, restore and the flag-write priority rule all act regardless of InstrValid.
- Counters:
  - On a valid instruction (InstrValid=1), CondEx=1 increments ExecCount and CondEx=0 increments SquashCount.
  - Both counters saturate at all-ones and do not wrap.
  - CntClr=1 zeroes both counters, with priority over increment.
  - Counters ignore FlagSave/FlagRestore.
- Bubbles (InstrValid=0): no gated outputs asserted, no flag write, no count. CondEx still reflects Flags/Cond.
- Reset asserted mid-operation clears all state immediately, independent of clk.

Decomposition:
- Shared package holds:
  - condition code constants COND_EQ…COND_AL, COND_NV
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One natural sub-module: cond_check, a purely combinational evaluation of (Cond, Flags) -> CondEx.
- The flag, shadow and counter registers stay in cond_logic.

Test Plan:
1. Reset low with Cond=1110, RegW=1, InstrValid=1 -> Flags=0000, counters=0, CondEx=1, RegWrite=1. Reset high, Cond=0000 -> CondEx=0, RegWrite=0.
2. ALUFlags=0100, FlagW=11, Cond=1110, one clock -> Flags=0100. Next instruction Cond=0000 (EQ) gives CondEx=1; Cond=1000 (HI) gives CondEx=0.
3. Flags=0100, next instruction Cond=0001 (NE) with FlagW=11 and ALUFlags=1000 -> CondEx=0, Flags stays 0100, SquashCount increments by 1.
4. FlagW=10, ALUFlags=1011, Cond=1110 from Flags=0100 -> Flags=1000 (C,V untouched). Sweep all 16 Cond codes over all 16 flag values against the golden table.
5. Flags=0110: FlagSave -> SavedFlags=0110. Then ALU write 1001 -> Flags=1001. Then FlagRestore with simultaneous FlagW=11, ALUFlags=1111 -> Flags=0110. Save+restore together -> swap.
6. CNT_W=4, 20 valid AL instructions -> ExecCount=1111 (saturated). CntClr with concurrent valid instruction -> ExecCount=0. Reset pulsed mid-sequence -> all state 0 asynchronously.
